// File: rtl/spi_master_byte_pkg.sv
// Shared definitions for the single-byte SPI mode-0 master: state encodings,
// default sck divider and byte width.
`timescale 1ns/1ps
package spi_master_byte_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam int DEF_CLK_DIV = 4;
  localparam int BYTE_W      = 8;

endpackage

// File: rtl/spi_clkgen.sv
// Phase timer for the SPI master: one-cycle tick every CLK_DIV cycles while en,
// counter held at zero while disabled so every phase starts from a clean count.
`timescale 1ns/1ps
module spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = en && (div_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_byte.sv
// Single-byte SPI mode-0 master, MSB first: start/tx_data in, cs/sck/mosi out,
// miso sampled on rising sck, rx_data returned with a one-cycle done pulse.
`timescale 1ns/1ps
module spi_master_byte
  import spi_master_byte_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] rx_data,
  output logic              sck,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-2:0] tx_sh;   // bit 7 goes straight to mosi at accept, only 7 bits left to shift
  logic [BYTE_W-1:0] rx_sh;
  logic              tick;

  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sck     <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh   <= tx_data[BYTE_W-2:0];
            mosi    <= tx_data[BYTE_W-1];
            cs      <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sck   <= 1'b1;
            rx_sh <= {rx_sh[BYTE_W-2:0], miso};
            state <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sck <= 1'b0;
            if (bit_cnt != 3'd7) begin
              mosi  <= tx_sh[BYTE_W-2];
              tx_sh <= {tx_sh[BYTE_W-3:0], 1'b0};
              state <= LOW;
            end else begin
              state <= HOLD;
            end
          end
        end
        LOW: begin
          if (tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            sck     <= 1'b1;
            rx_sh   <= {rx_sh[BYTE_W-2:0], miso};
            state   <= HIGH;
          end
        end
        HOLD: begin
          if (tick) begin
            cs      <= 1'b1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            state   <= GAP;
          end
        end
        GAP: begin
          // keeps busy high through the deselect time so start cannot shorten it
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte at CLK_DIV 4 and 1 with a behavioural mode-0 slave.
`timescale 1ns/1ps
module tb_spi_master_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       start   [2];
  logic [7:0] tx_data [2];
  logic       busy    [2];
  logic       done    [2];
  logic [7:0] rx_data [2];
  logic       sck     [2];
  logic       cs      [2];
  logic       mosi    [2];
  logic       miso    [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] ret_byte [2];
  logic [7:0] s_rx     [2];
  logic [7:0] last_cap [2];
  logic [7:0] prev_cap [2];
  int s_rises [2], last_rises [2], cap_cnt [2], acc_cnt [2], acc_cyc [2];
  int cs_rise_cyc [2], gap [2], done_cnt [2], done_cyc [2], busy_fall_cyc [2], mosi_viol [2];
  logic cs_p [2] = '{1'b1, 1'b1};
  logic sck_p [2] = '{1'b0, 1'b0};
  logic busy_p [2] = '{1'b0, 1'b0};
  logic mosi_p [2] = '{1'b0, 1'b0};

  spi_master_byte #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx_data[0]), .busy(busy[0]),
    .done(done[0]), .rx_data(rx_data[0]), .sck(sck[0]), .cs(cs[0]), .mosi(mosi[0]),
    .miso(miso[0])
  );

  spi_master_byte #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx_data[1]), .busy(busy[1]),
    .done(done[1]), .rx_data(rx_data[1]), .sck(sck[1]), .cs(cs[1]), .mosi(mosi[1]),
    .miso(miso[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave presents bit 7-k before rise k; drives 1 while deselected.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      miso[g] = 1'b1;
      if (!cs[g] && s_rises[g] < 8) miso[g] = ret_byte[g][3'(7 - s_rises[g])];
    end
  end

  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      if (cs_p[g] && !cs[g]) begin
        acc_cnt[g]++;
        acc_cyc[g] = cyc;
        gap[g] = cyc - cs_rise_cyc[g];
        s_rises[g] = 0;
        s_rx[g] = 8'h00;
      end
      if (!cs[g] && sck[g] && !sck_p[g]) begin
        s_rx[g] = {s_rx[g][6:0], mosi[g]};
        s_rises[g]++;
      end
      if (!cs_p[g] && cs[g]) begin
        cs_rise_cyc[g] = cyc;
        prev_cap[g] = last_cap[g];
        last_cap[g] = s_rx[g];
        last_rises[g] = s_rises[g];
        cap_cnt[g]++;
      end
      if (done[g]) begin
        done_cnt[g]++;
        done_cyc[g] = cyc;
      end
      if (busy_p[g] && !busy[g]) busy_fall_cyc[g] = cyc;
      if (sck[g] && mosi[g] !== mosi_p[g]) mosi_viol[g]++;
      cs_p[g] = cs[g];
      sck_p[g] = sck[g];
      busy_p[g] = busy[g];
      mosi_p[g] = mosi[g];
    end
  end

  task automatic wait_idle(input int i, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy[i]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = '{1'b0, 1'b0};
    tx_data = '{8'h00, 8'h00};
    ret_byte = '{8'h00, 8'h00};
    repeat (3) @(negedge clk);
    vectors++; if (cs[0] !== 1'b1) begin miscompares++; $display("FAIL reset_cs: got %b expected 1", cs[0]); end
    vectors++; if (sck[0] !== 1'b0) begin miscompares++; $display("FAIL reset_sck: got %b expected 0", sck[0]); end
    vectors++; if (mosi[0] !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b expected 0", mosi[0]); end
    vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
    vectors++; if (done[0] !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done[0]); end
    vectors++; if (rx_data[0] !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", rx_data[0]); end
    vectors++; if (cs[1] !== 1'b1 || sck[1] !== 1'b0) begin miscompares++; $display("FAIL reset_div1: got cs=%b sck=%b expected cs=1 sck=0", cs[1], sck[1]); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_transfer(input int i, input logic [7:0] tx, input logic [7:0] ret);
    int d, d0, c0, k0, v0;
    bit ok;
    d = (i == 0) ? 4 : 1;
    ret_byte[i] = ret;
    d0 = done_cnt[i]; c0 = acc_cnt[i]; k0 = cap_cnt[i]; v0 = mosi_viol[i];
    @(negedge clk); start[i] = 1'b1; tx_data[i] = tx;
    @(negedge clk); start[i] = 1'b0; tx_data[i] = 8'($urandom);
    wait_idle(i, 40 * d + 10, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL xfer_timeout[%0d]: busy still %b expected 0", i, busy[i]); end
    vectors++; if (last_cap[i] !== tx) begin miscompares++; $display("FAIL xfer_slave_rx[%0d]: got %h expected %h", i, last_cap[i], tx); end
    vectors++; if (rx_data[i] !== ret) begin miscompares++; $display("FAIL xfer_rx_data[%0d]: got %h expected %h", i, rx_data[i], ret); end
    vectors++; if (done_cnt[i] - d0 != 1) begin miscompares++; $display("FAIL xfer_done_count[%0d]: got %0d expected 1", i, done_cnt[i] - d0); end
    vectors++; if (acc_cnt[i] - c0 != 1 || cap_cnt[i] - k0 != 1) begin miscompares++; $display("FAIL xfer_cs_count[%0d]: got %0d/%0d expected 1/1", i, acc_cnt[i] - c0, cap_cnt[i] - k0); end
    vectors++; if (done_cyc[i] - acc_cyc[i] != 17 * d) begin miscompares++; $display("FAIL xfer_done_time[%0d]: got N+%0d expected N+%0d", i, done_cyc[i] - acc_cyc[i], 17 * d); end
    vectors++; if (cs_rise_cyc[i] - acc_cyc[i] != 17 * d) begin miscompares++; $display("FAIL xfer_cs_rise_time[%0d]: got N+%0d expected N+%0d", i, cs_rise_cyc[i] - acc_cyc[i], 17 * d); end
    vectors++; if (busy_fall_cyc[i] - acc_cyc[i] != 18 * d) begin miscompares++; $display("FAIL xfer_busy_time[%0d]: got N+%0d expected N+%0d", i, busy_fall_cyc[i] - acc_cyc[i], 18 * d); end
    vectors++; if (last_rises[i] != 8) begin miscompares++; $display("FAIL xfer_sck_rises[%0d]: got %0d expected 8", i, last_rises[i]); end
    vectors++; if (mosi_viol[i] != v0) begin miscompares++; $display("FAIL xfer_mosi_stable[%0d]: got %0d changes with sck high expected 0", i, mosi_viol[i] - v0); end
  endtask

  task automatic test_back_to_back();
    int c0;
    bit ok1, ok2, ok3;
    ret_byte[0] = 8'h96; c0 = acc_cnt[0];
    @(negedge clk); start[0] = 1'b1; tx_data[0] = 8'h81;
    ok1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (acc_cnt[0] == c0 + 1) begin ok1 = 1'b1; break; end
    end
    tx_data[0] = 8'h7E;
    ok2 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc_cnt[0] == c0 + 2) begin ok2 = 1'b1; break; end
    end
    start[0] = 1'b0;
    wait_idle(0, 200, ok3);
    vectors++; if (!(ok1 && ok2 && ok3)) begin miscompares++; $display("FAIL b2b_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
    vectors++; if (gap[0] != 5) begin miscompares++; $display("FAIL b2b_cs_gap: got %0d cycles expected 5", gap[0]); end
    vectors++; if (prev_cap[0] !== 8'h81) begin miscompares++; $display("FAIL b2b_first_byte: got %h expected 81", prev_cap[0]); end
    vectors++; if (last_cap[0] !== 8'h7E) begin miscompares++; $display("FAIL b2b_second_byte: got %h expected 7e", last_cap[0]); end
    vectors++; if (rx_data[0] !== 8'h96) begin miscompares++; $display("FAIL b2b_rx_data: got %h expected 96", rx_data[0]); end
  endtask

  task automatic test_ignored_start();
    int c0, d0, k0;
    bit ok1, ok2, ok3;
    logic [7:0] ret;
    ret = 8'($urandom);
    ret_byte[0] = ret; c0 = acc_cnt[0]; d0 = done_cnt[0]; k0 = cap_cnt[0];
    @(negedge clk); start[0] = 1'b1; tx_data[0] = 8'h55;
    @(negedge clk); start[0] = 1'b0; tx_data[0] = 8'hFF;
    ok1 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (cyc == acc_cyc[0] + 9) begin ok1 = 1'b1; break; end
      @(negedge clk);
    end
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    ok2 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cs[0]) begin ok2 = 1'b1; break; end
    end
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_idle(0, 50, ok3);
    repeat (20) @(negedge clk);
    vectors++; if (!(ok1 && ok2 && ok3)) begin miscompares++; $display("FAIL ign_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
    vectors++; if (acc_cnt[0] - c0 != 1) begin miscompares++; $display("FAIL ign_transactions: got %0d expected 1", acc_cnt[0] - c0); end
    vectors++; if (done_cnt[0] - d0 != 1) begin miscompares++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt[0] - d0); end
    vectors++; if (last_cap[0] !== 8'h55 || cap_cnt[0] - k0 != 1) begin miscompares++; $display("FAIL ign_mosi_byte: got %h (%0d) expected 55 (1)", last_cap[0], cap_cnt[0] - k0); end
    vectors++; if (rx_data[0] !== ret) begin miscompares++; $display("FAIL ign_rx_data: got %h expected %h", rx_data[0], ret); end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok;
    ret_byte[0] = 8'($urandom); d0 = done_cnt[0];
    @(negedge clk); start[0] = 1'b1; tx_data[0] = 8'($urandom);
    @(negedge clk); start[0] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_rises[0] == 4) begin ok = 1'b1; break; end
    end
    vectors++; if (!ok || cs[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_reach_rise4: got ok=%b cs=%b expected ok=1 cs=0", ok, cs[0]); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (cs[0] !== 1'b1) begin miscompares++; $display("FAIL rmid_cs_async: got %b expected 1", cs[0]); end
    vectors++; if (sck[0] !== 1'b0 || busy[0] !== 1'b0 || mosi[0] !== 1'b0 || done[0] !== 1'b0) begin
      miscompares++; $display("FAIL rmid_outputs: got sck=%b busy=%b mosi=%b done=%b expected all 0", sck[0], busy[0], mosi[0], done[0]);
    end
    vectors++; if (rx_data[0] !== 8'h00) begin miscompares++; $display("FAIL rmid_rx_clear: got %h expected 00", rx_data[0]); end
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    vectors++; if (done_cnt[0] != d0) begin miscompares++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done_cnt[0] - d0); end
    vectors++; if (rx_data[0] !== 8'h00 || cs[0] !== 1'b1) begin miscompares++; $display("FAIL rmid_idle_after: got rx=%h cs=%b expected rx=00 cs=1", rx_data[0], cs[0]); end
    test_transfer(0, 8'hC3, 8'($urandom));
  endtask

  task automatic test_clkdiv1();
    test_transfer(1, 8'hAA, 8'h55);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) test_transfer(0, 8'($urandom), 8'($urandom));
    for (int k = 0; k < 4; k++) test_transfer(1, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_transfer(0, 8'h3C, 8'hA2);
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_clkdiv1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
